cplx_mac_pipe: RTL

Pipelined fixed-point complex multiplier and multiply-accumulator with a valid/ready stream interface. It replaces the single-register complex multiply path in the datapath. It adds:
- parametrised component width and Q-format
- conjugate and accumulate (dot-product) modes
- round-half-up with saturation
- full backpressure

Operands and results use packed {real, imag} words, with real in the upper half.

---
 rtl/cplx_mac_pipe.sv | 173 +++++++++++++++++
 1 files changed

// File: rtl/cplx_mac_pipe.sv
// Pipelined fixed-point complex multiplier / multiply-accumulator with valid/ready
// stream ports. Stages: operand capture, products, combine, accumulate+round/saturate.
module cplx_mac_pipe #(
    parameter int WIDTH = 32,
    parameter int FRAC  = 15,
    parameter int GUARD = 8
) (
    input  logic             clock,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in1,
    input  logic [WIDTH-1:0] in2,
    input  logic [1:0]       mode,
    input  logic             last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] op,
    output logic             sat
);
    localparam int H  = WIDTH / 2;
    localparam int PW = 2 * H;
    localparam int SW = 2 * H + 1;
    localparam int AW = 2 * H + 1 + GUARD;

    localparam logic signed [AW:0] HALF_LSB = {{AW{1'b0}}, 1'b1} << (FRAC - 1);
    localparam logic signed [AW:0] MAX_V    = {{(AW - H + 2){1'b0}}, {(H - 1){1'b1}}};
    localparam logic signed [AW:0] MIN_V    = {{(AW - H + 2){1'b1}}, {(H - 1){1'b0}}};

    // Round half toward +inf, drop FRAC bits, clamp to H bits; MSB of result is the sat flag.
    function automatic logic [H:0] round_sat(input logic signed [AW-1:0] v);
        logic signed [AW:0] rnd;
        logic signed [AW:0] sh;
        rnd = {v[AW-1], v} + HALF_LSB;
        sh  = rnd >>> FRAC;
        if (sh > MAX_V) begin
            return {1'b1, MAX_V[H-1:0]};
        end else if (sh < MIN_V) begin
            return {1'b1, MIN_V[H-1:0]};
        end else begin
            return {1'b0, sh[H-1:0]};
        end
    endfunction

    logic                 en_s;
    logic                 s1_v_r, s1_last_r;
    logic [1:0]           s1_mode_r;
    logic signed [H-1:0]  s1_ar_r, s1_ai_r, s1_br_r, s1_bi_r;
    logic                 s2_v_r, s2_last_r;
    logic [1:0]           s2_mode_r;
    logic signed [PW-1:0] s2_rr_r, s2_ii_r, s2_ri_r, s2_ir_r;
    logic                 s3_v_r, s3_last_r, s3_acc_r;
    logic signed [SW-1:0] s3_re_r, s3_im_r;
    logic signed [AW-1:0] acc_re_r, acc_im_r;
    logic signed [AW-1:0] sum_re_s, sum_im_s, res_re_s, res_im_s;
    logic                 emit_s;
    logic [H:0]           rs_re_s, rs_im_s;

    // A stalled output freezes the whole pipe, accumulator included.
    assign en_s     = !out_valid || out_ready;
    assign in_ready = en_s;

    // Stage 1: operand capture.
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            s1_v_r    <= 1'b0;
            s1_last_r <= 1'b0;
            s1_mode_r <= 2'b00;
            s1_ar_r   <= '0;
            s1_ai_r   <= '0;
            s1_br_r   <= '0;
            s1_bi_r   <= '0;
        end else if (en_s) begin
            s1_v_r    <= in_valid;
            s1_last_r <= last;
            s1_mode_r <= mode;
            s1_ar_r   <= in1[WIDTH-1:H];
            s1_ai_r   <= in1[H-1:0];
            s1_br_r   <= in2[WIDTH-1:H];
            s1_bi_r   <= in2[H-1:0];
        end
    end

    // Stage 2: four full-precision signed products.
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            s2_v_r    <= 1'b0;
            s2_last_r <= 1'b0;
            s2_mode_r <= 2'b00;
            s2_rr_r   <= '0;
            s2_ii_r   <= '0;
            s2_ri_r   <= '0;
            s2_ir_r   <= '0;
        end else if (en_s) begin
            s2_v_r    <= s1_v_r;
            s2_last_r <= s1_last_r;
            s2_mode_r <= s1_mode_r;
            s2_rr_r   <= PW'(s1_ar_r) * PW'(s1_br_r);
            s2_ii_r   <= PW'(s1_ai_r) * PW'(s1_bi_r);
            s2_ri_r   <= PW'(s1_ar_r) * PW'(s1_bi_r);
            s2_ir_r   <= PW'(s1_ai_r) * PW'(s1_br_r);
        end
    end

    // Stage 3: combine products; mode bit 0 selects conj(B).
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            s3_v_r    <= 1'b0;
            s3_last_r <= 1'b0;
            s3_acc_r  <= 1'b0;
            s3_re_r   <= '0;
            s3_im_r   <= '0;
        end else if (en_s) begin
            s3_v_r    <= s2_v_r;
            s3_last_r <= s2_last_r;
            s3_acc_r  <= s2_mode_r[1];
            if (s2_mode_r[0]) begin
                s3_re_r <= SW'(s2_rr_r) + SW'(s2_ii_r);
                s3_im_r <= SW'(s2_ir_r) - SW'(s2_ri_r);
            end else begin
                s3_re_r <= SW'(s2_rr_r) - SW'(s2_ii_r);
                s3_im_r <= SW'(s2_ri_r) + SW'(s2_ir_r);
            end
        end
    end

    // Result selection (pass-through or accumulated) and output scaling.
    always_comb begin
        sum_re_s = acc_re_r + AW'(s3_re_r);
        sum_im_s = acc_im_r + AW'(s3_im_r);
        res_re_s = AW'(s3_re_r);
        res_im_s = AW'(s3_im_r);
        if (s3_acc_r) begin
            res_re_s = sum_re_s;
            res_im_s = sum_im_s;
        end else begin
            res_re_s = AW'(s3_re_r);
            res_im_s = AW'(s3_im_r);
        end
        emit_s  = s3_v_r && (!s3_acc_r || s3_last_r);
        rs_re_s = round_sat(res_re_s);
        rs_im_s = round_sat(res_im_s);
    end

    // Accumulator: grows on open accumulate beats, clears when the closing beat emits.
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            acc_re_r <= '0;
            acc_im_r <= '0;
        end else if (en_s && s3_v_r && s3_acc_r) begin
            if (s3_last_r) begin
                acc_re_r <= '0;
                acc_im_r <= '0;
            end else begin
                acc_re_r <= sum_re_s;
                acc_im_r <= sum_im_s;
            end
        end
    end

    // Output register.
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            op        <= '0;
            sat       <= 1'b0;
        end else if (en_s) begin
            out_valid <= emit_s;
            op        <= {rs_re_s[H-1:0], rs_im_s[H-1:0]};
            sat       <= rs_re_s[H] | rs_im_s[H];
        end
    end
endmodule
